// File: rtl/gmii_rx_fcs_check.sv
// GMII rx frame checker: strips preamble/SFD, forwards DA..payload, checks FCS.
// Optional destination MAC filter enabled by defining RX_MAC_FILTER_EN.
module gmii_rx_fcs_check #(
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518,
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        frame_start,
  output logic        frame_valid,
  output logic [7:0]  frame_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [15:0] frame_len,
  output logic        mac_miss,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        sfd_hit;
  logic        data_en;
  logic        end_frame;
  logic        pre_abort;
  logic        drop_exit;
  logic [31:0] crc_q;
  logic [15:0] byte_cnt;
  logic [31:0] dly_q;
  logic [2:0]  dly_cnt;
  logic        fwd_v;
  logic [7:0]  fwd_d;
  logic        crc_bad;
  logic        len_bad;
  logic        miss_now;
  logic        good_inc;
  logic        bad_inc;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle event strobes
  always_comb begin
    state_nx  = state;
    sfd_hit   = 1'b0;
    data_en   = 1'b0;
    end_frame = 1'b0;
    pre_abort = 1'b0;
    drop_exit = 1'b0;
    unique case (state)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) state_nx = PREAMBLE;
          else                   state_nx = DROP;
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_nx  = IDLE;
          pre_abort = 1'b1;
        end else if (gmii_rxd == 8'hD5) begin
          state_nx = DATA;
          sfd_hit  = 1'b1;
        end else if (gmii_rxd != 8'h55) begin
          state_nx = DROP;
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          data_en = 1'b1;
        end else begin
          state_nx  = IDLE;
          end_frame = 1'b1;
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          state_nx  = IDLE;
          drop_exit = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // CRC, byte counter and the 4-byte FCS holdback line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= 32'hFFFFFFFF;
      byte_cnt    <= 16'd0;
      dly_q       <= 32'd0;
      dly_cnt     <= 3'd0;
      fwd_v       <= 1'b0;
      fwd_d       <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= sfd_hit;
      fwd_v       <= 1'b0;
      if (sfd_hit) begin
        crc_q    <= 32'hFFFFFFFF;
        byte_cnt <= 16'd0;
        dly_cnt  <= 3'd0;
      end else if (data_en) begin
        crc_q <= crc_byte(crc_q, gmii_rxd);
        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
        dly_q <= {dly_q[23:0], gmii_rxd};
        if (dly_cnt == 3'd4) begin
          fwd_v <= 1'b1;
          fwd_d <= dly_q[31:24];
        end else begin
          dly_cnt <= dly_cnt + 3'd1;
        end
      end else if (end_frame) begin
        dly_cnt <= 3'd0;
      end
    end
  end

  assign crc_bad = (crc_q != CRC_RES);
  assign len_bad = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);

`ifdef RX_MAC_FILTER_EN
  logic       mac_bd;
  logic       mac_bc;
  logic       bd_nx;
  logic       bc_nx;
  logic       chk;
  logic [7:0] mac_ref;

  // Expected DA byte for the current byte position
  always_comb begin
    mac_ref = 8'h00;
    case (byte_cnt[2:0])
      3'd0:    mac_ref = BOARD_MAC[47:40];
      3'd1:    mac_ref = BOARD_MAC[39:32];
      3'd2:    mac_ref = BOARD_MAC[31:24];
      3'd3:    mac_ref = BOARD_MAC[23:16];
      3'd4:    mac_ref = BOARD_MAC[15:8];
      3'd5:    mac_ref = BOARD_MAC[7:0];
      default: mac_ref = 8'h00;
    endcase
  end

  assign chk      = data_en && (byte_cnt < 16'd6);
  assign bd_nx    = mac_bd & (!chk | (gmii_rxd == mac_ref));
  assign bc_nx    = mac_bc & (!chk | (gmii_rxd == 8'hFF));
  assign miss_now = !(mac_bd | mac_bc);

  // Running DA match flags, re-armed at each SFD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_bd <= 1'b1;
      mac_bc <= 1'b1;
    end else if (sfd_hit) begin
      mac_bd <= 1'b1;
      mac_bc <= 1'b1;
    end else begin
      mac_bd <= bd_nx;
      mac_bc <= bc_nx;
    end
  end

  // Extra stage so byte 0 waits until DA byte 5 is judged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_data  <= 8'd0;
    end else begin
      frame_valid <= fwd_v & (bd_nx | bc_nx);
      frame_data  <= fwd_d;
    end
  end

  // Filter verdict, held like the other status bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            mac_miss <= 1'b0;
    else if (end_frame) mac_miss <= miss_now;
  end
`else
  assign miss_now    = 1'b0;
  assign frame_valid = fwd_v;
  assign frame_data  = fwd_d;
  // Constant 0; keeps BOARD_MAC referenced in the unfiltered build
  assign mac_miss    = 1'b0 & (|BOARD_MAC);
`endif

  // End-of-frame status, held until the next frame_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      frame_len  <= 16'd0;
    end else begin
      frame_done <= end_frame;
      if (end_frame) begin
        frame_ok  <= !crc_bad && !len_bad && !miss_now;
        crc_err   <= crc_bad;
        len_err   <= len_bad;
        frame_len <= byte_cnt;
      end
    end
  end

  assign good_inc = end_frame && !miss_now && !crc_bad && !len_bad;
  assign bad_inc  = (end_frame && !miss_now && (crc_bad || len_bad))
                  || pre_abort || drop_exit;

  // Saturating good/bad frame counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= 16'd0;
      bad_cnt  <= 16'd0;
    end else begin
      if (good_inc && good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      if (bad_inc && bad_cnt != 16'hFFFF)   bad_cnt  <= bad_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Scoreboard bench for gmii_rx_fcs_check.
// Define RX_MAC_FILTER_EN to also exercise the DA filter.
module tb_gmii_rx_fcs_check;

  localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct packed {
    logic        ok;
    logic        ce;
    logic        le;
    logic [15:0] len;
    logic        miss;
    logic [15:0] good;
    logic [15:0] bad;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        frame_start;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        frame_done;
  logic        frame_ok;
  logic        crc_err;
  logic        len_err;
  logic [15:0] frame_len;
  logic        mac_miss;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          start_due = -1;
  int          fwd_seen = 0;
  int          done_seen = 0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad = 16'd0;
  logic [7:0]  exp_q[$];
  st_t         st_q[$];
  logic [7:0]  frm[$];
  logic [7:0]  mon_b;
  st_t         mon_st;
  st_t         mon_obs;

  gmii_rx_fcs_check dut (
    .clk         (clk),
    .rst         (rst),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .frame_start (frame_start),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .crc_err     (crc_err),
    .len_err     (len_err),
    .frame_len   (frame_len),
    .mac_miss    (mac_miss),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: SFD pulse timing, forwarded bytes, status
  always @(negedge clk) begin
    if (frame_start === 1'b1 || cyc == start_due) begin
      vectors++;
      if (!(frame_start === 1'b1 && cyc == start_due)) begin
        miscompares++;
        $display("FAIL frame_start: got %b at cycle %0d, due at %0d",
                 frame_start, cyc, start_due);
      end
    end
    if (frame_valid === 1'b1) begin
      fwd_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fwd_extra: got %h, expected no byte", frame_data);
      end else begin
        mon_b = exp_q.pop_front();
        if (frame_data !== mon_b) begin
          miscompares++;
          $display("FAIL fwd_data: got %h, expected %h", frame_data, mon_b);
        end
      end
    end
    if (frame_done === 1'b1) begin
      done_seen++;
      vectors++;
      mon_obs = {frame_ok, crc_err, len_err, frame_len,
                 mac_miss, good_cnt, bad_cnt};
      if (st_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_extra: got status %h, expected no frame_done",
                 mon_obs);
      end else begin
        mon_st = st_q.pop_front();
        if (mon_obs !== mon_st) begin
          miscompares++;
          $display("FAIL status: got %h, expected %h", mon_obs, mon_st);
        end
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++)
      r = {1'b0, r[31:1]} ^ (r[0] ? 32'hEDB88320 : 32'd0);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = v;
    gmii_rxd   = d;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    gmii_rx_dv = 1'b0;
    exp_q.delete();
    st_q.delete();
    exp_good   = 16'd0;
    exp_bad    = 16'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Builds DA + random body + FCS into frm, pushes expected results
  task automatic build_frame(input int len, input bit corrupt,
                             input logic [47:0] da);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    bit          miss;
    bit          le;
    bit          ok;
    st_t         s;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      if (i < 6) b = da[8*(5-i) +: 8];
      else       b = 8'($urandom);
      c = crc_upd(c, b);
      frm.push_back(b);
    end
    fcs = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    if (corrupt) frm[len-1] = frm[len-1] ^ 8'h01;
`ifdef RX_MAC_FILTER_EN
    miss = (da != MAC) && (da != BCAST);
`else
    miss = 1'b0;
`endif
    le = (len < 64) || (len > 1518);
    ok = !corrupt && !le && !miss;
    if (!miss) begin
      if (ok) exp_good++;
      else    exp_bad++;
      for (int i = 0; i < len - 4; i++) exp_q.push_back(frm[i]);
    end
    s = '{ok: ok, ce: corrupt, le: le, len: 16'(len), miss: miss,
          good: exp_good, bad: exp_bad};
    st_q.push_back(s);
  endtask

  task automatic send_frame(input int len, input bit corrupt,
                            input logic [47:0] da);
    build_frame(len, corrupt, da);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    start_due = cyc + 1;
    for (int i = 0; i < len; i++) drive(1'b1, frm[i]);
    drive(1'b0, 8'($urandom));
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    settle(3);
    vectors++;
    if ({frame_start, frame_valid, frame_data, frame_done, frame_ok,
         crc_err, len_err, frame_len, mac_miss, good_cnt, bad_cnt} !== 52'd0)
    begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rst = 1'b0;
    drive(1'b0, 8'hD5);
    drive(1'b0, 8'h55);
    settle(2);
    vectors++;
    if ({frame_start, frame_valid, frame_done, good_cnt, bad_cnt} !== 35'd0)
    begin
      miscompares++;
      $display("FAIL idle_ignore: got activity with dv=0, expected none");
    end
  endtask

  task automatic test_good_frame();
    fwd_seen = 0;
    send_frame(64, 1'b0, MAC);
    settle(3);
    vectors++;
    if (fwd_seen != 60 || st_q.size() != 0 || good_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL good_frame: got fwd=%0d pend=%0d good=%0d, need 60/0/1",
               fwd_seen, st_q.size(), good_cnt);
    end
  endtask

  task automatic test_bad_fcs();
    fwd_seen = 0;
    send_frame(64, 1'b1, MAC);
    settle(3);
    vectors++;
    if (fwd_seen != 60 || st_q.size() != 0 || bad_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL bad_fcs: got fwd=%0d pend=%0d bad=%0d, need 60/0/1",
               fwd_seen, st_q.size(), bad_cnt);
    end
  endtask

  task automatic test_length();
    fwd_seen = 0;
    send_frame(40, 1'b0, MAC);
    send_frame(1600, 1'b0, MAC);
    send_frame(4, 1'b0, MAC);
    settle(3);
    vectors++;
    if (fwd_seen != 36 + 1596 || st_q.size() != 0 || bad_cnt !== exp_bad)
    begin
      miscompares++;
      $display("FAIL length: got fwd=%0d pend=%0d bad=%0d, need %0d/0/%0d",
               fwd_seen, st_q.size(), bad_cnt, 36 + 1596, exp_bad);
    end
  endtask

  task automatic test_aborts();
    int d0;
    d0 = done_seen;
    drive(1'b1, 8'h55);
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hAA);
    drive(1'b1, 8'hD5);
    drive(1'b0, 8'h00);
    exp_bad++;
    settle(2);
    vectors++;
    if (bad_cnt !== exp_bad || done_seen != d0) begin
      miscompares++;
      $display("FAIL drop_abort: got bad=%0d dones=%0d, need %0d/%0d",
               bad_cnt, done_seen - d0, exp_bad, 0);
    end
    repeat (3) drive(1'b1, 8'h55);
    drive(1'b0, 8'hD5);
    exp_bad++;
    settle(2);
    vectors++;
    if (bad_cnt !== exp_bad || done_seen != d0) begin
      miscompares++;
      $display("FAIL pre_abort: got bad=%0d dones=%0d, need %0d/%0d",
               bad_cnt, done_seen - d0, exp_bad, 0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset();
    d0       = done_seen;
    fwd_seen = 0;
    send_frame(64, 1'b0, MAC);
    send_frame(64, 1'b0, MAC);
    settle(3);
    vectors++;
    if (good_cnt !== 16'd2 || done_seen - d0 != 2 || fwd_seen != 120) begin
      miscompares++;
      $display("FAIL back_to_back: got good=%0d dones=%0d fwd=%0d, need 2/2/120",
               good_cnt, done_seen - d0, fwd_seen);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_seen;
    build_frame(64, 1'b0, MAC);
    repeat (7) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    start_due = cyc + 1;
    for (int i = 0; i < 24; i++) drive(1'b1, frm[i]);
    @(negedge clk);
    gmii_rxd = frm[24];
    rst      = 1'b1;
    #1;
    vectors++;
    if ({frame_start, frame_valid, frame_data, frame_done, frame_ok,
         crc_err, len_err, frame_len, mac_miss, good_cnt, bad_cnt} !== 52'd0)
    begin
      miscompares++;
      $display("FAIL rst_mid: got nonzero outputs in reset, expected all 0");
    end
    exp_q.delete();
    st_q.delete();
    exp_good = 16'd0;
    exp_bad  = 16'd1;
    fwd_seen = 0;
    drive(1'b1, 8'h00);
    rst = 1'b0;
    repeat (5) drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    settle(3);
    vectors++;
    if (fwd_seen != 0 || done_seen != d0 || bad_cnt !== exp_bad
        || good_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid_after: got fwd=%0d dones=%0d bad=%0d good=%0d, need 0/0/1/0",
               fwd_seen, done_seen - d0, bad_cnt, good_cnt);
    end
  endtask

`ifdef RX_MAC_FILTER_EN
  task automatic test_mac_filter();
    do_reset();
    fwd_seen = 0;
    send_frame(64, 1'b0, 48'h00_11_22_33_44_56);
    settle(3);
    vectors++;
    if (fwd_seen != 0 || good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL mac_miss: got fwd=%0d good=%0d bad=%0d, need 0/0/0",
               fwd_seen, good_cnt, bad_cnt);
    end
    send_frame(64, 1'b0, BCAST);
    settle(3);
    vectors++;
    if (fwd_seen != 60 || good_cnt !== 16'd1 || st_q.size() != 0) begin
      miscompares++;
      $display("FAIL mac_bcast: got fwd=%0d good=%0d pend=%0d, need 60/1/0",
               fwd_seen, good_cnt, st_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_length();
    test_aborts();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef RX_MAC_FILTER_EN
    test_mac_filter();
`endif
    settle(2);
    vectors++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d bytes %0d status pending, expected 0/0",
               exp_q.size(), st_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
